bpc_de_blk_collector: RTL

Block collector sitting directly downstream of `BPC_DECOMP` in the bit-plane compression decoder path. It accepts the decompressed 64-bit word stream (8 words per block, framed by sop/eop) and checks the framing. Complete blocks go into a two-bank ping-pong buffer. Each block is re-emitted as 128-bit beats, tagged with a running block index, toward the memory write port. Malformed blocks are dropped and flagged, so the write side only ever sees whole blocks.

---
 rtl/bpc_pkg.sv | 33 +++
 rtl/bpc_blk_bank.sv | 35 +++
 rtl/bpc_de_blk_collector.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bpc_pkg.sv
// Shared constants, beat payload and framing classification for the
// bit-plane compression decoder datapath.
package bpc_pkg;

  localparam int unsigned BPC_WORD_W        = 64;
  localparam int unsigned BPC_WORDS_PER_BLK = 8;
  localparam int unsigned BPC_BEAT_W        = 128;

  typedef struct packed {
    logic [BPC_WORD_W-1:0] hi;
    logic [BPC_WORD_W-1:0] lo;
  } bpc_beat_t;

  // What the write side does with one accepted input word.
  typedef enum logic [2:0] {
    FR_STORE    = 3'd0,
    FR_FIRST    = 3'd1,
    FR_RESTART  = 3'd2,
    FR_COMPLETE = 3'd3,
    FR_ABORT    = 3'd4
  } fr_act_e;

  // A stray sop always restarts a block, so it is tested ahead of the eop rules.
  function automatic fr_act_e fr_classify(input logic at_first, input logic at_last,
                                          input logic sop, input logic eop);
    if (at_first) return (sop && !eop) ? FR_FIRST : FR_ABORT;
    if (sop)      return FR_RESTART;
    if (at_last)  return eop ? FR_COMPLETE : FR_ABORT;
    if (eop)      return FR_ABORT;
    return FR_STORE;
  endfunction

endpackage

// File: rtl/bpc_blk_bank.sv
// Two-bank block store: one 64-bit word write port, one 128-bit beat read port.
module bpc_blk_bank
  import bpc_pkg::*;
#(
  parameter int unsigned WORDS      = BPC_WORDS_PER_BLK,
  parameter int unsigned CNT_W      = $clog2(WORDS),
  parameter int unsigned BEAT_CNT_W = (WORDS / 2 > 1) ? $clog2(WORDS / 2) : 1
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic                  wr_bank_i,
  input  logic [CNT_W-1:0]      wr_idx_i,
  input  logic [BPC_WORD_W-1:0] wr_data_i,
  input  logic                  rd_bank_i,
  input  logic [BEAT_CNT_W-1:0] rd_beat_i,
  output bpc_beat_t             rd_data_o
);

  logic [BPC_WORD_W-1:0] mem_q [2][WORDS];
  logic [CNT_W-1:0]      rd_lo_idx;
  logic [CNT_W-1:0]      rd_hi_idx;

  // Pure data storage; validity is tracked by the full flags in the parent.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_bank_i][wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_lo_idx    = CNT_W'({rd_beat_i, 1'b0});
  assign rd_hi_idx    = rd_lo_idx | CNT_W'(1);
  assign rd_data_o.lo = mem_q[rd_bank_i][rd_lo_idx];
  assign rd_data_o.hi = mem_q[rd_bank_i][rd_hi_idx];

endmodule

// File: rtl/bpc_de_blk_collector.sv
// Checks block framing of the decompressed word stream, buffers whole blocks
// in a ping-pong store and re-emits them as indexed 128-bit beats.
module bpc_de_blk_collector
  import bpc_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLK = BPC_WORDS_PER_BLK,
  parameter int unsigned IDX_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BPC_WORD_W-1:0] data_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [BPC_BEAT_W-1:0] data_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [IDX_W-1:0]      blk_idx_o,
  output logic                  err_o,
  input  logic                  err_clr_i
);

  localparam int unsigned BEATS      = WORDS_PER_BLK / 2;
  localparam int unsigned CNT_W      = $clog2(WORDS_PER_BLK);
  localparam int unsigned BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [BEAT_CNT_W-1:0] rd_beat_q, rd_beat_d;
  logic [1:0]            full_q, full_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  err_q, err_d;

  logic                  in_hs;
  logic                  out_hs;
  logic                  rd_last;
  logic                  err_set;
  logic                  wr_en;
  logic [CNT_W-1:0]      wr_idx;
  fr_act_e               act;
  bpc_beat_t             rd_data;

  assign ready_o = ~full_q[wr_bank_q];
  assign valid_o = full_q[rd_bank_q];
  assign in_hs   = valid_i & ready_o;
  assign out_hs  = valid_o & ready_i;
  assign rd_last = (rd_beat_q == BEAT_CNT_W'(BEATS - 1));
  assign act     = fr_classify(wr_cnt_q == '0, wr_cnt_q == CNT_W'(WORDS_PER_BLK - 1),
                               sop_i, eop_i);

  // Write-side framing and read-side release; set and clear of full hit different banks.
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_beat_d = rd_beat_q;
    full_d    = full_q;
    idx_d     = idx_q;
    err_set   = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = wr_cnt_q;

    if (in_hs) begin
      unique case (act)
        FR_FIRST: begin
          wr_en    = 1'b1;
          wr_idx   = '0;
          wr_cnt_d = CNT_W'(1);
        end
        FR_RESTART: begin
          wr_en    = 1'b1;
          wr_idx   = '0;
          wr_cnt_d = CNT_W'(1);
          err_set  = 1'b1;
        end
        FR_STORE: begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
        FR_COMPLETE: begin
          wr_en             = 1'b1;
          wr_cnt_d          = '0;
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
        FR_ABORT: begin
          wr_cnt_d = '0;
          err_set  = 1'b1;
        end
        default: ;
      endcase
    end

    if (out_hs) begin
      if (rd_last) begin
        rd_beat_d         = '0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        idx_d             = idx_q + IDX_W'(1);
      end else begin
        rd_beat_d = rd_beat_q + BEAT_CNT_W'(1);
      end
    end

    err_d = err_set | (err_q & ~err_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_beat_q <= '0;
      full_q    <= 2'b00;
      idx_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_beat_q <= rd_beat_d;
      full_q    <= full_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
    end
  end

  bpc_blk_bank #(
    .WORDS      (WORDS_PER_BLK),
    .CNT_W      (CNT_W),
    .BEAT_CNT_W (BEAT_CNT_W)
  ) u_bank (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_bank_i (wr_bank_q),
    .wr_idx_i  (wr_idx),
    .wr_data_i (data_i),
    .rd_bank_i (rd_bank_q),
    .rd_beat_i (rd_beat_q),
    .rd_data_o (rd_data)
  );

  // Stale bank contents are masked so the output bus reads 0 when idle.
  assign data_o    = valid_o ? rd_data : '0;
  assign sop_o     = valid_o & (rd_beat_q == '0);
  assign eop_o     = valid_o & rd_last;
  assign blk_idx_o = idx_q;
  assign err_o     = err_q;

endmodule
